// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with fixed wait states, stall
// injection, two-cycle ERROR responses and read-after-write forwarding.
module ahb_sram_slave #(
   parameter int          DATA_WDT    = 32,
   parameter int          DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0
) (
   input  logic                i_hclk,
   input  logic                i_hreset_n,
   input  logic                i_hsel,
   input  logic [31:0]         i_haddr,
   input  logic [1:0]          i_htrans,
   input  logic                i_hwrite,
   input  logic [2:0]          i_hsize,
   input  logic [2:0]          i_hburst,
   input  logic [3:0]          i_hprot,
   input  logic                i_hmastlock,
   input  logic [DATA_WDT-1:0] i_hwdata,
   input  logic                i_hready,
   input  logic                i_stall,
   output logic [DATA_WDT-1:0] o_hrdata,
   output logic                o_hready,
   output logic [1:0]          o_hresp
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LANES = DATA_WDT / 8;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WDT-1:0]   mem [DEPTH];

   logic [DEPTH_LOG2-1:0] idx_p1;
   logic [LANES-1:0]      lanes_p1;
   logic                  wr_p1;

   logic                  accept, take, addr_bad, wr_done, load_rd;
   logic [DEPTH_LOG2-1:0] addr_idx, rd_idx;
   logic [LANES-1:0]      addr_lanes;
   logic [DATA_WDT-1:0]   rd_word;
   logic                  unused_inputs;

   assign unused_inputs = ^{i_htrans[0], i_hburst, i_hprot, i_hmastlock};

   function automatic logic [LANES-1:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'b000:  lane_mask = LANES'(1) << lo;
         3'b001:  lane_mask = lo[1] ? LANES'(4'b1100) : LANES'(4'b0011);
         default: lane_mask = '1;
      endcase
   endfunction

   // Address phase decode
   assign accept     = i_hsel & i_hready & i_htrans[1];
   assign addr_idx   = i_haddr[DEPTH_LOG2+1:2];
   assign addr_lanes = lane_mask(i_hsize, i_haddr[1:0]);

   always_comb begin
      addr_bad = 1'b0;
      if (i_hsize > 3'b010)                             addr_bad = 1'b1;
      if (i_hsize == 3'b001 && i_haddr[0])              addr_bad = 1'b1;
      if (i_hsize == 3'b010 && i_haddr[1:0] != 2'b00)   addr_bad = 1'b1;
      if (i_haddr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2]) addr_bad = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      o_hready = 1'b1;
      o_hresp  = 2'b00;
      take     = 1'b0;
      case (state_q)
         ST_IDLE: take = 1'b1;
         ST_WAIT: begin
            o_hready = 1'b0;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_DATA;
         end
         ST_DATA: begin
            o_hready = ~i_stall;
            if (!i_stall) begin
               take    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ERR1: begin
            o_hready = 1'b0;
            o_hresp  = 2'b01;
            state_d  = ST_ERR2;
         end
         ST_ERR2: begin
            o_hresp = 2'b01;
            take    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (take && accept) begin
         if (addr_bad) begin
            state_d = ST_ERR1;
         end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
         end else begin
            state_d = ST_DATA;
         end
      end
   end

   // Read word fetch; a write completing this edge to the same word is merged in
   assign wr_done = (state_q == ST_DATA) & ~i_stall & wr_p1;
   assign rd_idx  = (state_q == ST_WAIT) ? idx_p1 : addr_idx;
   assign load_rd = (take & accept & ~addr_bad & ~i_hwrite & (WAIT_STATES == 0)) |
                    ((state_q == ST_WAIT) & (cnt_q == 4'd1) & ~wr_p1);

   always_comb begin
      rd_word = mem[rd_idx];
      if (wr_done && idx_p1 == rd_idx) begin
         for (int b = 0; b < LANES; b++) begin
            if (lanes_p1[b]) rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
         end
      end
   end

   // Data phase registers
   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wr_p1    <= 1'b0;
         o_hrdata <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (take && accept) wr_p1 <= i_hwrite;
         if (load_rd)        o_hrdata <= rd_word;
      end
   end

   always_ff @(posedge i_hclk) begin
      if (take && accept) begin
         idx_p1   <= addr_idx;
         lanes_p1 <= addr_lanes;
      end
      if (wr_done) begin
         for (int b = 0; b < LANES; b++) begin
            if (lanes_p1[b]) mem[idx_p1][8*b +: 8] <= i_hwdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with two wait states, one with none.
module tb_ahb_sram_slave;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, hsel, tgt, hwrite, hmastlock, stall;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic        sel_a, sel_b, rdy_a, rdy_b, rdy_t;
   logic [1:0]  resp_a, resp_b, resp_t;
   logic [31:0] rd_a, rd_b, rd_t;
   int          vec = 0;
   int          errs = 0;

   assign sel_a  = hsel & ~tgt;
   assign sel_b  = hsel & tgt;
   assign rdy_t  = tgt ? rdy_b : rdy_a;
   assign resp_t = tgt ? resp_b : resp_a;
   assign rd_t   = tgt ? rd_b : rd_a;

   ahb_sram_slave #(.DATA_WDT(32), .DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut_a (
      .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel_a), .i_haddr(haddr), .i_htrans(htrans),
      .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
      .i_hmastlock(hmastlock), .i_hwdata(hwdata), .i_hready(rdy_a), .i_stall(stall),
      .o_hrdata(rd_a), .o_hready(rdy_a), .o_hresp(resp_a));

   ahb_sram_slave #(.DATA_WDT(32), .DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_b (
      .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel_b), .i_haddr(haddr), .i_htrans(htrans),
      .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
      .i_hmastlock(hmastlock), .i_hwdata(hwdata), .i_hready(rdy_b), .i_stall(stall),
      .o_hrdata(rd_b), .o_hready(rdy_b), .o_hresp(resp_b));

   // Single non-pipelined transfer; cycles = data phase length, 999 if it never ends
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic [1:0] resp, output int cycles, output logic rdy1,
                          output logic [1:0] resp1, output logic [31:0] rd1);
      bit done;
      @(negedge clk);
      hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
      cycles = 0; done = 0; rdata = '0; resp = '0; rdy1 = 1'b0; resp1 = '0; rd1 = '0;
      while (!done && cycles < 50) begin
         #1;
         cycles++;
         if (cycles == 1) begin rdy1 = rdy_t; resp1 = resp_t; rd1 = rd_t; end
         if (rdy_t) begin
            done = 1; rdata = rd_t; resp = resp_t;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) cycles = 999;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; tgt = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0; hwdata = '0;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vec++; if (rdy_a !== 1'b1)  begin errs++; $display("FAIL reset_hready_a: got %b want 1", rdy_a); end
      vec++; if (resp_a !== 2'b00) begin errs++; $display("FAIL reset_hresp_a: got %b want 00", resp_a); end
      vec++; if (rd_a !== 32'h0)   begin errs++; $display("FAIL reset_hrdata_a: got %h want 0", rd_a); end
      vec++; if (rdy_b !== 1'b1)  begin errs++; $display("FAIL reset_hready_b: got %b want 1", rdy_b); end
      vec++; if (rd_b !== 32'h0)   begin errs++; $display("FAIL reset_hrdata_b: got %h want 0", rd_b); end
      rst_n = 1'b1;
      hsel = 1'b1; htrans = 2'b00; haddr = 32'h10;
      @(negedge clk); #1;
      vec++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin errs++; $display("FAIL idle_okay: got %b/%b want 1/00", rdy_a, resp_a); end
      htrans = 2'b01;
      @(negedge clk); #1;
      vec++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin errs++; $display("FAIL busy_okay: got %b/%b want 1/00", rdy_a, resp_a); end
      hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1;
      @(negedge clk); #1;
      vec++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin errs++; $display("FAIL unselected_okay: got %b/%b want 1/00", rdy_a, resp_a); end
      htrans = 2'b00; hwrite = 1'b0;
   endtask

   task automatic test_wait_states;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      tgt = 1'b0;
      do_xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (cyc !== 3 || rs !== 2'b00) begin errs++; $display("FAIL ws2_write: got %0d cyc resp %b want 3/00", cyc, rs); end
      do_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (cyc !== 3) begin errs++; $display("FAIL ws2_read_len: got %0d want 3", cyc); end
      vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ws2_read_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      tgt = 1'b0;
      do_xfer(1'b1, 32'h13, 3'b000, 32'hAA000000, rd, rs, cyc, r1, rs1, rd1);
      do_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'hAAADBEEF) begin errs++; $display("FAIL byte3_write: got %h want aaadbeef", rd); end
      do_xfer(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, rd, rs, cyc, r1, rs1, rd1);
      do_xfer(1'b1, 32'h20, 3'b001, 32'h00001234, rd, rs, cyc, r1, rs1, rd1);
      do_xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'hCAFE1234) begin errs++; $display("FAIL half_lo_write: got %h want cafe1234", rd); end
      do_xfer(1'b1, 32'h22, 3'b001, 32'h56780000, rd, rs, cyc, r1, rs1, rd1);
      do_xfer(1'b1, 32'h20, 3'b000, 32'h00000077, rd, rs, cyc, r1, rs1, rd1);
      do_xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'h56781277) begin errs++; $display("FAIL half_hi_byte0: got %h want 56781277", rd); end
   endtask

   task automatic test_error;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      logic [31:0] e_addr [5] = '{32'h02, 32'h1000, 32'h1010, 32'h21, 32'h40};
      logic [2:0]  e_size [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b011};
      logic        e_wr   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tgt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_xfer(e_wr[i], e_addr[i], e_size[i], 32'h0, rd, rs, cyc, r1, rs1, rd1);
         vec++; if (cyc !== 2) begin errs++; $display("FAIL err%0d_len: got %0d want 2", i, cyc); end
         vec++; if (r1 !== 1'b0 || rs1 !== 2'b01) begin errs++; $display("FAIL err%0d_err1: got %b/%b want 0/01", i, r1, rs1); end
         vec++; if (rs !== 2'b01) begin errs++; $display("FAIL err%0d_err2: got resp %b want 01", i, rs); end
         vec++; if (rd1 !== 32'h56781277 || rd !== 32'h56781277) begin errs++; $display("FAIL err%0d_rdata: got %h/%h want 56781277", i, rd1, rd); end
      end
      do_xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'hAAADBEEF || rs !== 2'b00) begin errs++; $display("FAIL err_no_alias: got %h/%b want aaadbeef/00", rd, rs); end
      do_xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'h56781277) begin errs++; $display("FAIL err_no_write: got %h want 56781277", rd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      tgt = 1'b1;
      do_xfer(1'b1, 32'h40, 3'b010, 32'h11223344, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (cyc !== 1 || rs !== 2'b00) begin errs++; $display("FAIL ws0_write: got %0d cyc resp %b want 1/00", cyc, rs); end
      @(negedge clk);
      hsel = 1'b1; haddr = 32'h41; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b000;
      @(negedge clk);
      hwdata = 32'h0000AA00; haddr = 32'h40; hwrite = 1'b0; hsize = 3'b010;
      #1;
      vec++; if (rdy_b !== 1'b1) begin errs++; $display("FAIL raw_write_phase: got hready %b want 1", rdy_b); end
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00;
      #1;
      vec++; if (rdy_b !== 1'b1 || resp_b !== 2'b00) begin errs++; $display("FAIL raw_read_phase: got %b/%b want 1/00", rdy_b, resp_b); end
      vec++; if (rd_b !== 32'h1122AA44) begin errs++; $display("FAIL raw_forward: got %h want 1122aa44", rd_b); end
      do_xfer(1'b0, 32'h40, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (cyc !== 1 || rd !== 32'h1122AA44) begin errs++; $display("FAIL raw_commit: got %0d cyc %h want 1/1122aa44", cyc, rd); end
   endtask

   task automatic test_burst;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      int a_idx, d_idx, ncyc, bad;
      logic rdy; bit busy;
      tgt = 1'b0; hburst = 3'b001; hmastlock = 1'b1;
      a_idx = 0; d_idx = -1; ncyc = 0; bad = 0;
      while ((a_idx < 42 || d_idx >= 0) && ncyc < 2000) begin
         @(negedge clk);
         ncyc++;
         stall = ($urandom_range(0, 3) == 0);
         busy  = (a_idx > 0) && (a_idx < 42) && ($urandom_range(0, 4) == 0);
         if (a_idx < 42) begin
            hsel = 1'b1; haddr = 32'h100 + 32'(a_idx * 4); hwrite = 1'b1; hsize = 3'b010;
            htrans = busy ? 2'b01 : ((a_idx == 0) ? 2'b10 : 2'b11);
         end else begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
         end
         hwdata = (d_idx >= 0) ? 32'(d_idx) : 32'h0;
         #1;
         rdy = rdy_t;
         if (d_idx >= 0 && rdy && resp_t !== 2'b00) bad++;
         @(posedge clk);
         if (rdy) begin
            if (a_idx < 42 && !busy) begin d_idx = a_idx; a_idx++; end
            else d_idx = -1;
         end
      end
      @(negedge clk);
      stall = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hmastlock = 1'b0; hburst = 3'b000;
      vec++; if (a_idx !== 42 || d_idx !== -1) begin errs++; $display("FAIL burst_done: got beat %0d pending %0d want 42/-1", a_idx, d_idx); end
      vec++; if (bad !== 0) begin errs++; $display("FAIL burst_resp: got %0d non-OKAY beats want 0", bad); end
      for (int i = 0; i < 42; i++) begin
         do_xfer(1'b0, 32'h100 + 32'(i * 4), 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
         vec++; if (rd !== 32'(i) || rs !== 2'b00) begin errs++; $display("FAIL burst_read%0d: got %h/%b want %h/00", i, rd, rs, 32'(i)); end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd, rd1; logic [1:0] rs, rs1; logic r1; int cyc;
      tgt = 1'b0;
      do_xfer(1'b1, 32'h30, 3'b010, 32'h55667788, rd, rs, cyc, r1, rs1, rd1);
      @(negedge clk);
      hsel = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFFFFFF; stall = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vec++; if (rdy_a !== 1'b0) begin errs++; $display("FAIL stalled_phase: got hready %b want 0", rdy_a); end
      rst_n = 1'b0;
      #1;
      vec++; if (rdy_a !== 1'b1 || resp_a !== 2'b00) begin errs++; $display("FAIL async_reset_ready: got %b/%b want 1/00", rdy_a, resp_a); end
      vec++; if (rd_a !== 32'h0) begin errs++; $display("FAIL async_reset_rdata: got %h want 0", rd_a); end
      @(posedge clk);
      @(negedge clk);
      stall = 1'b0; rst_n = 1'b1;
      do_xfer(1'b0, 32'h30, 3'b010, 32'h0, rd, rs, cyc, r1, rs1, rd1);
      vec++; if (rd !== 32'h55667788) begin errs++; $display("FAIL reset_drop_write: got %h want 55667788", rd); end
   endtask

   initial begin
      test_reset;
      test_wait_states;
      test_byte_lanes;
      test_error;
      test_back_to_back;
      test_burst;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
